// File: rtl/branch_resolve.sv
// EX-stage branch resolution: computes the branch target, issues a registered fetch redirect,
// sequences a multi-cycle flush of younger stages and keeps saturating branch statistics.
module branch_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_pc,
    input  logic [15:0]      ex_imm16,
    input  logic [31:0]      cmp_s,
    input  logic             stall,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    localparam logic [2:0]       FlushInit = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             redirect_q, redirect_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic        acc;
    logic        taken;
    logic [31:0] target;

    // Branches seen outside IDLE belong to squashed instructions and are dropped.
    assign acc    = ex_valid & ex_is_branch & ~stall & (state_q == StIdle);
    assign taken  = acc & cmp_s[0];
    assign target = ex_pc + 32'd4 + {{14{ex_imm16[15]}}, ex_imm16, 2'b00};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_d    = redirect_q;
        redirect_pc_d = redirect_pc_q;
        flush_d       = flush_q;
        busy_d        = busy_q;

        if (!stall) begin
            unique case (state_q)
                StIdle: begin
                    redirect_d = 1'b0;
                    flush_d    = 1'b0;
                    busy_d     = 1'b0;
                    if (taken) begin
                        state_d       = StFlush;
                        cnt_d         = FlushInit;
                        redirect_d    = 1'b1;
                        redirect_pc_d = target;
                        flush_d       = 1'b1;
                        busy_d        = 1'b1;
                    end
                end
                StFlush: begin
                    redirect_d = 1'b0;
                    if (cnt_q == 3'd0) begin
                        state_d = StIdle;
                        flush_d = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // acc and taken already exclude stalled cycles, so the statistics freeze with the pipe.
    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (acc && (br_count_q != CntMax)) begin
            br_count_d = br_count_q + CntOne;
        end
        if (taken && (taken_count_q != CntMax)) begin
            taken_count_d = taken_count_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= 3'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            br_count_q    <= '0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
            busy_q        <= busy_d;
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign flush       = flush_q;
    assign busy        = busy_q;
    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares; a narrow-counter instance covers saturation.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        reset, ex_valid, ex_is_branch, stall;
    logic [31:0] ex_pc, cmp_s;
    logic [15:0] ex_imm16;
    logic        redirect, flush, busy;
    logic [31:0] redirect_pc;
    logic [15:0] br_count, taken_count;

    logic        s_reset, s_valid, s_branch, s_stall;
    logic [31:0] s_pc, s_cmp;
    logic [15:0] s_imm;
    logic        s_redirect, s_flush, s_busy;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_br_count, s_taken_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic        red;
        logic [31:0] rpc;
        logic        fl;
        logic        bsy;
        logic [15:0] bc;
        logic [15:0] tc;
    } exp_t;

    exp_t exp_q[$];
    int   vec_idx = 0;

    always #5 clk = ~clk;

    branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_pc(ex_pc), .ex_imm16(ex_imm16), .cmp_s(cmp_s), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
        .br_count(br_count), .taken_count(taken_count)
    );

    branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(s_reset), .ex_valid(s_valid), .ex_is_branch(s_branch),
        .ex_pc(s_pc), .ex_imm16(s_imm), .cmp_s(s_cmp), .stall(s_stall),
        .redirect(s_redirect), .redirect_pc(s_redirect_pc), .flush(s_flush), .busy(s_busy),
        .br_count(s_br_count), .taken_count(s_taken_count)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, expv);
        end
    endtask

    // Apply one cycle of inputs; the expectation describes outputs after the next rising edge.
    task automatic cyc(input logic rst, input logic v, input logic br, input logic [31:0] pc,
                       input logic [15:0] imm, input logic [31:0] cmp, input logic stl,
                       input logic e_red, input logic [31:0] e_rpc, input logic e_fl,
                       input logic e_bsy, input logic [15:0] e_bc, input logic [15:0] e_tc);
        exp_t e;
        @(negedge clk);
        reset = rst; ex_valid = v; ex_is_branch = br; ex_pc = pc;
        ex_imm16 = imm; cmp_s = cmp; stall = stl;
        @(posedge clk);
        #1;
        e.idx = vec_idx; e.red = e_red; e.rpc = e_rpc; e.fl = e_fl;
        e.bsy = e_bsy; e.bc = e_bc; e.tc = e_tc;
        exp_q.push_back(e);
        vec_idx++;
    endtask

    task automatic idle(input logic e_red, input logic [31:0] e_rpc, input logic e_fl,
                        input logic e_bsy, input logic [15:0] e_bc, input logic [15:0] e_tc);
        cyc(0, 0, 0, 32'h0, 16'h0, 32'h0, 0, e_red, e_rpc, e_fl, e_bsy, e_bc, e_tc);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("redirect", e.idx, {31'd0, redirect}, {31'd0, e.red});
                check("redirect_pc", e.idx, redirect_pc, e.rpc);
                check("flush", e.idx, {31'd0, flush}, {31'd0, e.fl});
                check("busy", e.idx, {31'd0, busy}, {31'd0, e.bsy});
                check("br_count", e.idx, {16'd0, br_count}, {16'd0, e.bc});
                check("taken_count", e.idx, {16'd0, taken_count}, {16'd0, e.tc});
            end
        end
    end

    initial begin : driver
        int waited;
        reset = 1; ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_imm16 = 0; cmp_s = 0; stall = 0;
        s_reset = 1; s_valid = 0; s_branch = 0; s_pc = 0; s_imm = 0; s_cmp = 0; s_stall = 0;

        // Reset state
        cyc(1, 0, 0, 32'h0, 16'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0);
        // Taken branch, two-cycle flush
        cyc(0, 1, 1, 32'h0040_0010, 16'h0003, 32'h1, 0, 1, 32'h0040_0020, 1, 1, 1, 1);
        idle(0, 32'h0040_0020, 1, 1, 1, 1);
        idle(0, 32'h0040_0020, 0, 0, 1, 1);
        // Not taken: only bit 0 of cmp_s matters
        cyc(0, 1, 1, 32'h0040_0010, 16'h0003, 32'hFFFF_FFFE, 0, 0, 32'h0040_0020, 0, 0, 2, 1);
        idle(0, 32'h0040_0020, 0, 0, 2, 1);
        // Negative offset wrapping below zero
        cyc(0, 1, 1, 32'h0000_0000, 16'hFFFE, 32'h1, 0, 1, 32'hFFFF_FFFC, 1, 1, 3, 2);
        idle(0, 32'hFFFF_FFFC, 1, 1, 3, 2);
        idle(0, 32'hFFFF_FFFC, 0, 0, 3, 2);
        // PC+4 wrapping past the top
        cyc(0, 1, 1, 32'hFFFF_FFFC, 16'h0000, 32'h1, 0, 1, 32'h0000_0000, 1, 1, 4, 3);
        idle(0, 32'h0, 1, 1, 4, 3);
        idle(0, 32'h0, 0, 0, 4, 3);
        // Stall for 3 cycles in the first flush cycle, with a branch on the inputs
        cyc(0, 1, 1, 32'h0000_1000, 16'h0010, 32'h1, 0, 1, 32'h0000_1044, 1, 1, 5, 4);
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 1, 32'h0000_5000, 16'h0001, 32'h1, 1, 1, 32'h0000_1044, 1, 1, 5, 4);
        idle(0, 32'h0000_1044, 1, 1, 5, 4);
        idle(0, 32'h0000_1044, 0, 0, 5, 4);
        // Branch during flush and on the exit edge is ignored, next IDLE accepts
        cyc(0, 1, 1, 32'h0000_2000, 16'h0001, 32'h1, 0, 1, 32'h0000_2008, 1, 1, 6, 5);
        cyc(0, 1, 1, 32'h0000_3000, 16'h0001, 32'h1, 0, 0, 32'h0000_2008, 1, 1, 6, 5);
        cyc(0, 1, 1, 32'h0000_3000, 16'h0001, 32'h1, 0, 0, 32'h0000_2008, 0, 0, 6, 5);
        cyc(0, 1, 1, 32'h0000_3000, 16'h0001, 32'h1, 0, 1, 32'h0000_3008, 1, 1, 7, 6);
        idle(0, 32'h0000_3008, 1, 1, 7, 6);
        idle(0, 32'h0000_3008, 0, 0, 7, 6);
        // Reset in the first flush cycle aborts everything
        cyc(0, 1, 1, 32'h0000_4000, 16'h0000, 32'h1, 0, 1, 32'h0000_4004, 1, 1, 8, 7);
        cyc(1, 1, 1, 32'h0000_4000, 16'h0000, 32'h1, 0, 0, 32'h0, 0, 0, 0, 0);
        idle(0, 32'h0, 0, 0, 0, 0);
        // Non-branch and invalid cycles, then a stalled branch: nothing accepted
        cyc(0, 1, 0, 32'h0000_6000, 16'h0001, 32'h1, 0, 0, 32'h0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h0000_6000, 16'h0001, 32'h1, 0, 0, 32'h0, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h0000_6000, 16'h0001, 32'h1, 1, 0, 32'h0, 0, 0, 0, 0);
        // Offset of -1 word lands back on the branch itself
        cyc(0, 1, 1, 32'h0000_0100, 16'hFFFF, 32'h1, 0, 1, 32'h0000_0100, 1, 1, 1, 1);
        idle(0, 32'h0000_0100, 1, 1, 1, 1);
        idle(0, 32'h0000_0100, 0, 0, 1, 1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        // Narrow counters: a held taken branch is accepted every 3 cycles
        @(negedge clk);
        s_reset = 1;
        @(negedge clk);
        check("sat_reset_br", 0, {28'd0, s_br_count}, 32'h0);
        check("sat_reset_taken", 0, {28'd0, s_taken_count}, 32'h0);
        s_reset = 0; s_valid = 1; s_branch = 1; s_pc = 32'h0000_0800; s_cmp = 32'h1;
        repeat (60) @(negedge clk);
        check("sat_br", 1, {28'd0, s_br_count}, 32'hF);
        check("sat_taken", 1, {28'd0, s_taken_count}, 32'hF);
        repeat (10) @(negedge clk);
        check("sat_br_hold", 2, {28'd0, s_br_count}, 32'hF);
        check("sat_taken_hold", 2, {28'd0, s_taken_count}, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
